// File: rtl/tea_block_cipher_pkg.sv
// Shared TEA constants, block/key types, FSM state encoding and the round mixing function.
// Imported by tea_round, tea_block_cipher and its interface users.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

  typedef struct packed {
    logic [31:0] v0;
    logic [31:0] v1;
  } block_t;

  // First member lands in the MSBs, so k0 = key[127:96] ... k3 = key[31:0].
  typedef struct packed {
    logic [31:0] k0;
    logic [31:0] k1;
    logic [31:0] k2;
    logic [31:0] k3;
  } key_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] tea_mix(
    input logic [31:0] v,
    input logic [31:0] sum,
    input logic [31:0] ka,
    input logic [31:0] kb
  );
    return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_block_cipher_if.sv
// Host-side and result-side valid/ready handshake bundle for tea_block_cipher.
// The core connects through the slave modport, the host through master.
interface tea_block_cipher_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_decrypt;
  logic [31:0]  in_v0;
  logic [31:0]  in_v1;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_v0;
  logic [31:0]  out_v1;
  logic         busy;

  modport master (
    output in_valid, in_decrypt, in_v0, in_v1, in_key, out_ready,
    input  in_ready, out_valid, out_v0, out_v1, busy
  );

  modport slave (
    input  in_valid, in_decrypt, in_v0, in_v1, in_key, out_ready,
    output in_ready, out_valid, out_v0, out_v1, busy
  );
endinterface

// File: rtl/tea_block_cipher_round.sv
// Combinational single TEA round; the decrypt arm exists only when TEA_DECRYPT_EN is defined.
// Encrypt pre-increments sum, decrypt post-decrements it, so a chain of rounds composes directly.
module tea_round
  import tea_pkg::*;
(
  input  block_t      blk_in,
  input  logic [31:0] sum_in,
  input  key_t        key,
`ifdef TEA_DECRYPT_EN
  input  logic        decrypt,
`endif
  output block_t      blk_out,
  output logic [31:0] sum_out
);

  logic [31:0] enc_sum;
  logic [31:0] enc_v0;
  logic [31:0] enc_v1;

  assign enc_sum = sum_in + TEA_DELTA;
  assign enc_v0  = blk_in.v0 + tea_mix(blk_in.v1, enc_sum, key.k0, key.k1);
  assign enc_v1  = blk_in.v1 + tea_mix(enc_v0, enc_sum, key.k2, key.k3);

`ifdef TEA_DECRYPT_EN
  logic [31:0] dec_v0;
  logic [31:0] dec_v1;

  assign dec_v1 = blk_in.v1 - tea_mix(blk_in.v0, sum_in, key.k2, key.k3);
  assign dec_v0 = blk_in.v0 - tea_mix(dec_v1, sum_in, key.k0, key.k1);

  always_comb begin
    blk_out.v0 = enc_v0;
    blk_out.v1 = enc_v1;
    sum_out    = enc_sum;
    if (decrypt) begin
      blk_out.v0 = dec_v0;
      blk_out.v1 = dec_v1;
      sum_out    = sum_in - TEA_DELTA;
    end
  end
`else
  always_comb begin
    blk_out.v0 = enc_v0;
    blk_out.v1 = enc_v1;
    sum_out    = enc_sum;
  end
`endif

endmodule

// File: rtl/tea_block_cipher.sv
// Iterative TEA core: UNROLL chained rounds per clock, one block in flight, valid/ready on both sides.
// Define TEA_DECRYPT_EN to honour in_decrypt; otherwise every block is encrypted.
module tea_block_cipher
  import tea_pkg::*;
#(
  parameter int ROUNDS = 32,
  parameter int UNROLL = 1
) (
  input logic               clk,
  input logic               reset,
  tea_block_cipher_if.slave bus
);

  localparam int N     = (UNROLL > 0) ? ROUNDS / UNROLL : 0;
  localparam int CNT_W = (N < 1) ? 1 : $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  if (ROUNDS < 1 || ROUNDS > 64 || !(UNROLL == 1 || UNROLL == 2 || UNROLL == 4) ||
      (ROUNDS % UNROLL) != 0) begin : g_bad_params
    $error("tea_block_cipher: illegal ROUNDS=%0d / UNROLL=%0d", ROUNDS, UNROLL);
  end

  state_t           state_reg;
  block_t           blk_reg;
  key_t             key_reg;
  logic [31:0]      sum_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             in_ready_reg;
  logic             busy_reg;
  logic             out_valid_reg;
  logic [31:0]      out_v0_reg;
  logic [31:0]      out_v1_reg;

  block_t      blk_chain [UNROLL+1];
  logic [31:0] sum_chain [UNROLL+1];

  assign blk_chain[0] = blk_reg;
  assign sum_chain[0] = sum_reg;

`ifdef TEA_DECRYPT_EN
  // Decrypt walks the schedule backwards from the final encrypt sum.
  localparam logic [31:0] SUM_DEC = TEA_DELTA * 32'(ROUNDS);
  logic mode_reg;
`else
  logic unused_decrypt;
  assign unused_decrypt = bus.in_decrypt;
`endif

  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_round
    tea_round u_round (
      .blk_in  (blk_chain[gi]),
      .sum_in  (sum_chain[gi]),
      .key     (key_reg),
`ifdef TEA_DECRYPT_EN
      .decrypt (mode_reg),
`endif
      .blk_out (blk_chain[gi+1]),
      .sum_out (sum_chain[gi+1])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      blk_reg       <= '0;
      key_reg       <= '0;
      sum_reg       <= '0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_v0_reg    <= '0;
      out_v1_reg    <= '0;
`ifdef TEA_DECRYPT_EN
      mode_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            blk_reg.v0   <= bus.in_v0;
            blk_reg.v1   <= bus.in_v1;
            key_reg      <= bus.in_key;
            cnt_reg      <= '0;
            sum_reg      <= '0;
`ifdef TEA_DECRYPT_EN
            mode_reg     <= bus.in_decrypt;
            if (bus.in_decrypt) begin
              sum_reg    <= SUM_DEC;
            end
`endif
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          blk_reg <= blk_chain[UNROLL];
          sum_reg <= sum_chain[UNROLL];
          cnt_reg <= cnt_reg + 1'b1;
          // The edge that brings cnt to N also publishes the result.
          if (cnt_reg == CNT_LAST) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            out_v0_reg    <= blk_chain[UNROLL].v0;
            out_v1_reg    <= blk_chain[UNROLL].v1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.busy      = busy_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_v0    = out_v0_reg;
  assign bus.out_v1    = out_v1_reg;

endmodule

// File: tb/tb_tea_block_cipher.sv
// Directed bench: an UNROLL=1 and an UNROLL=4 core share one stimulus stream; results are
// checked against known TEA vectors and a reference encrypt loop.
module tb_tea_block_cipher;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  tea_block_cipher_if b1 ();
  tea_block_cipher_if b4 ();

  assign b4.in_valid   = b1.in_valid;
  assign b4.in_decrypt = b1.in_decrypt;
  assign b4.in_v0      = b1.in_v0;
  assign b4.in_v1      = b1.in_v1;
  assign b4.in_key     = b1.in_key;
  assign b4.out_ready  = b1.out_ready;

  tea_block_cipher #(.ROUNDS(32), .UNROLL(1)) d1 (.clk(clk), .reset(reset), .bus(b1));
  tea_block_cipher #(.ROUNDS(32), .UNROLL(4)) d4 (.clk(clk), .reset(reset), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_enc(input logic [31:0] a, input logic [31:0] b,
                                          input logic [127:0] k);
    logic [31:0] s;
    s = 32'd0;
    for (int i = 0; i < 32; i++) begin
      s = s + 32'h9E3779B9;
      a = a + (((b << 4) + k[127:96]) ^ (b + s) ^ ((b >> 5) + k[95:64]));
      b = b + (((a << 4) + k[63:32]) ^ (a + s) ^ ((a >> 5) + k[31:0]));
    end
    return {a, b};
  endfunction

  // Offer one block, measure latency on both cores, check results, then drain the output.
  task automatic run_block(input string tag, input logic [31:0] v0, input logic [31:0] v1,
                           input logic [127:0] key, input logic dec,
                           input logic [31:0] e0, input logic [31:0] e1);
    int cyc;
    int t1;
    int t4;
    @(negedge clk);
    check({tag, ".in_ready_before"}, 64'(b1.in_ready), 64'd1);
    b1.in_valid   = 1'b1;
    b1.in_decrypt = dec;
    b1.in_v0      = v0;
    b1.in_v1      = v1;
    b1.in_key     = key;
    @(posedge clk);
    @(negedge clk);
    b1.in_valid = 1'b0;
    b1.in_v0    = $urandom;
    b1.in_v1    = $urandom;
    b1.in_key   = {$urandom, $urandom, $urandom, $urandom};
    cyc = 0;
    t1  = 0;
    t4  = 0;
    while (t1 == 0 && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (b4.out_valid === 1'b1 && t4 == 0) t4 = cyc;
      if (b1.out_valid === 1'b1) t1 = cyc;
    end
    check({tag, ".latency_u1"}, 64'(t1), 64'd32);
    check({tag, ".latency_u4"}, 64'(t4), 64'd8);
    check({tag, ".out_u1"}, {b1.out_v0, b1.out_v1}, {e0, e1});
    check({tag, ".out_u4"}, {b4.out_v0, b4.out_v1}, {e0, e1});
    check({tag, ".done_in_ready"}, 64'(b1.in_ready), 64'd0);
    check({tag, ".done_busy"}, 64'(b1.busy), 64'd1);
    b1.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b1.out_ready = 1'b0;
    check({tag, ".after_out_valid"}, 64'(b1.out_valid), 64'd0);
    check({tag, ".after_in_ready"}, 64'(b1.in_ready), 64'd1);
    check({tag, ".after_busy_u4"}, 64'(b4.busy), 64'd0);
  endtask

  initial begin
    logic [31:0]  r0;
    logic [31:0]  r1;
    logic [127:0] rk;
    logic [63:0]  exp;
    logic [63:0]  held;
    int           cyc;
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    b1.in_valid   = 1'b0;
    b1.in_decrypt = 1'b0;
    b1.in_v0      = '0;
    b1.in_v1      = '0;
    b1.in_key     = '0;
    b1.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset.out_valid", 64'(b1.out_valid), 64'd0);
    check("reset.out_data", {b1.out_v0, b1.out_v1}, 64'd0);
    check("reset.busy", 64'(b1.busy), 64'd0);
    check("reset.in_ready", 64'(b1.in_ready), 64'd1);
    check("reset.u4_idle", {62'd0, b4.in_ready, b4.busy}, 64'd2);

    // Known vector: zero key, zero block.
    run_block("enc_zero", 32'h0, 32'h0, 128'h0, 1'b0, 32'h41EA3A0A, 32'h94BAA940);

`ifdef TEA_DECRYPT_EN
    run_block("dec_zero", 32'h41EA3A0A, 32'h94BAA940, 128'h0, 1'b1, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      r0  = $urandom;
      r1  = $urandom;
      rk  = {$urandom, $urandom, $urandom, $urandom};
      exp = ref_enc(r0, r1, rk);
      run_block("rt_enc", r0, r1, rk, 1'b0, exp[63:32], exp[31:0]);
      run_block("rt_dec", exp[63:32], exp[31:0], rk, 1'b1, r0, r1);
    end
`else
    // Mode request is ignored without the decrypt build.
    run_block("dec_ignored", 32'h0, 32'h0, 128'h0, 1'b1, 32'h41EA3A0A, 32'h94BAA940);
`endif

    for (int i = 0; i < 3; i++) begin
      r0  = $urandom;
      r1  = $urandom;
      rk  = {$urandom, $urandom, $urandom, $urandom};
      exp = ref_enc(r0, r1, rk);
      run_block("rand_enc", r0, r1, rk, 1'b0, exp[63:32], exp[31:0]);
    end

    // Back-pressure: hold out_ready low in DONE while a new block is offered.
    @(negedge clk);
    b1.in_valid   = 1'b1;
    b1.in_decrypt = 1'b0;
    b1.in_v0      = 32'h0;
    b1.in_v1      = 32'h0;
    b1.in_key     = 128'h0;
    @(posedge clk);
    @(negedge clk);
    b1.in_valid = 1'b0;
    cyc = 0;
    while (b1.out_valid !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("hold.reached_done", 64'(b1.out_valid), 64'd1);
    held          = {b1.out_v0, b1.out_v1};
    b1.in_valid   = 1'b1;
    b1.in_v0      = 32'h12345678;
    b1.in_v1      = 32'h9ABCDEF0;
    b1.in_key     = {4{32'hA5A5A5A5}};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold.out_valid", 64'(b1.out_valid), 64'd1);
      check("hold.data", {b1.out_v0, b1.out_v1}, 64'h41EA3A0A94BAA940);
      check("hold.in_ready", 64'(b1.in_ready), 64'd0);
    end
    check("hold.data_vs_first", {b1.out_v0, b1.out_v1}, held);
    b1.in_valid  = 1'b0;
    b1.out_ready = 1'b1;
    @(negedge clk);
    b1.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("hold.not_queued_busy", 64'(b1.busy), 64'd0);
    check("hold.not_queued_ready", 64'(b1.in_ready), 64'd1);

    // Abort mid-RUN with an asynchronous reset pulse.
    b1.in_valid = 1'b1;
    b1.in_v0    = 32'hDEADBEEF;
    b1.in_v1    = 32'h01234567;
    b1.in_key   = {32'h1, 32'h2, 32'h3, 32'h4};
    @(posedge clk);
    @(negedge clk);
    b1.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("abort.busy_before", 64'(b1.busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort.async_busy", 64'(b1.busy), 64'd0);
    @(negedge clk);
    check("abort.out_valid", 64'(b1.out_valid), 64'd0);
    check("abort.busy", 64'(b1.busy), 64'd0);
    check("abort.in_ready", 64'(b1.in_ready), 64'd1);
    check("abort.out_data", {b1.out_v0, b1.out_v1}, 64'd0);
    reset = 1'b0;
    exp = ref_enc(32'hCAFEF00D, 32'h0BADC0DE, {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});
    run_block("after_abort", 32'hCAFEF00D, 32'h0BADC0DE,
              {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 1'b0,
              exp[63:32], exp[31:0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
